// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// The clamp limit and saturation word are the six-digit display's largest value.
package bin_to_bcd_pkg;

  localparam int BCD_BIN_W = 20;
  localparam int CNT_W     = $clog2(BCD_BIN_W);

  localparam logic [19:0] BCD_MAX = 20'd999999;
  localparam logic [23:0] BCD_SAT = 24'h999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative shift-and-add-3 binary-to-BCD converter feeding the seven-segment
// display driver; bcd_out only updates on entry to DONE so the display never tears.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]    cnt;
  logic [BIN_W-1:0]    bin_sr;
  logic [4*DIGITS-1:0] acc;
  logic                ovf;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] acc_shift;
  logic [BIN_W-1:0]    bin_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc[4*d +: 4]),
      .digit_out (adj[4*d +: 4])
    );
  end

  // The binary MSB shifts into the corrected accumulator's LSB each iteration.
  always_comb begin
    {acc_shift, bin_shift} = {adj, bin_sr} << 1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state != IDLE) busy = 1'b1;
    if (state == DONE) done = 1'b1;
  end

  // Clamping at capture keeps digit 5 below 10, so no carry can leave the accumulator.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      bin_sr   <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= (bin_in > BCD_MAX) ? BCD_MAX : bin_in;
            ovf    <= (bin_in > BCD_MAX);
            acc    <= '0;
            cnt    <= CNT_W'(BIN_W - 1);
          end
        end
        SHIFT: begin
          acc    <= acc_shift;
          bin_sr <= bin_shift;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            bcd_out  <= acc_shift;
            overflow <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed-vector bench for bin_to_bcd: latency, saturation, ignored starts,
// back-to-back conversions and mid-conversion reset.
module tb_bin_to_bcd;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [19:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        overflow;

  int vectors;
  int miscompares;

  bin_to_bcd #(.BIN_W(20), .DIGITS(6)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin_in    (bin_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Accepts one value and returns the done-cycle offset (acceptance cycle = 0).
  task automatic do_conversion(input logic [19:0] value, output int latency,
                               output logic [23:0] result, output logic ovf_seen,
                               output logic busy_rise);
    bin_in = value;
    start  = 1'b1;
    step();
    start     = 1'b0;
    busy_rise = busy;
    latency   = 1;
    while (!done && latency < 40) begin
      step();
      latency++;
    end
    result   = bcd_out;
    ovf_seen = overflow;
    step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    bin_in    = '0;
    step();
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl busy=%b done=%b expected 0 0", busy, done);
    end
    vectors++;
    if (bcd_out !== 24'h000000 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data bcd=%h ovf=%b expected 000000 0", bcd_out, overflow);
    end
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat; logic [23:0] res; logic ov; logic br;
    do_conversion(20'd12345, lat, res, ov, br);
    vectors++;
    if (br !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_rise busy=%b expected 1", br);
    end
    vectors++;
    if (lat !== 21) begin
      miscompares++;
      $display("[TB] FAIL basic_latency got %0d expected 21", lat);
    end
    vectors++;
    if (res !== 24'h012345 || ov !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_result bcd=%h ovf=%b expected 012345 0", res, ov);
    end
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_after_done done=%b busy=%b expected 0 0", done, busy);
    end
    vectors++;
    if (bcd_out !== 24'h012345) begin
      miscompares++;
      $display("[TB] FAIL basic_hold bcd=%h expected 012345", bcd_out);
    end
  endtask

  task automatic test_boundaries();
    logic [19:0] vin  [4] = '{20'd0, 20'd999999, 20'hFFFFF, 20'd7};
    logic [23:0] vexp [4] = '{24'h000000, 24'h999999, 24'h999999, 24'h000007};
    logic        oexp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [23:0] res; logic ov; logic br;
    for (int i = 0; i < 4; i++) begin
      do_conversion(vin[i], lat, res, ov, br);
      vectors++;
      if (res !== vexp[i] || ov !== oexp[i] || lat !== 21) begin
        miscompares++;
        $display("[TB] FAIL boundary_%0d bcd=%h ovf=%b lat=%0d expected %h %b 21",
                 i, res, ov, lat, vexp[i], oexp[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int lat; logic [23:0] res; logic ov; logic br;
    logic [23:0] first_res = '0;
    bin_in = 20'd123456;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int off = 1; off <= 26; off++) begin
      start = 1'b0;
      if (done) begin
        dones++;
        first_res = bcd_out;
        bin_in = 20'd654321;
        start  = 1'b1;
      end
      if (off == 5) begin
        bin_in = 20'd654321;
        start  = 1'b1;
      end
      step();
    end
    start = 1'b0;
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("[TB] FAIL ignored_done_count got %0d expected 1", dones);
    end
    vectors++;
    if (first_res !== 24'h123456) begin
      miscompares++;
      $display("[TB] FAIL ignored_result bcd=%h expected 123456", first_res);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignored_idle busy=%b expected 0", busy);
    end
    do_conversion(20'd654321, lat, res, ov, br);
    vectors++;
    if (res !== 24'h654321 || lat !== 21) begin
      miscompares++;
      $display("[TB] FAIL ignored_next bcd=%h lat=%0d expected 654321 21", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_res [3] = '{24'h000001, 24'h000002, 24'h000003};
    int          exp_off [3] = '{21, 43, 65};
    logic [23:0] got_res [3];
    int          got_off [3];
    int n = 0;
    bin_in = 20'd1;
    start  = 1'b1;
    step();
    for (int off = 1; off <= 90 && n < 3; off++) begin
      if (done) begin
        got_res[n] = bcd_out;
        got_off[n] = off;
        n++;
        bin_in = 20'(n + 1);
        if (n == 3) start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got %0d expected 3", n);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_res[i] !== exp_res[i] || got_off[i] !== exp_off[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d bcd=%h at %0d expected %h at %0d",
                 i, got_res[i], got_off[i], exp_res[i], exp_off[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat; logic [23:0] res; logic ov; logic br;
    bin_in = 20'd999999;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int off = 1; off < 10; off++) step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 24'h000000 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs busy=%b done=%b bcd=%h ovf=%b expected 0 0 000000 0",
               busy, done, bcd_out, overflow);
    end
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      step();
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done got %0d pulses expected 0", dones);
    end
    do_conversion(20'd42, lat, res, ov, br);
    vectors++;
    if (res !== 24'h000042 || ov !== 1'b0 || lat !== 21) begin
      miscompares++;
      $display("[TB] FAIL midreset_fresh bcd=%h ovf=%b lat=%0d expected 000042 0 21", res, ov, lat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sys_rst_n   = 1'b0;
    start       = 1'b0;
    bin_in      = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
